imem_loader: RTL

//   Writer side of the instruction-memory interface. The pcpu only reads imem, so imem gets a

---
 rtl/imem_loader_pkg.sv | 21 ++
 rtl/imem_loader.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/imem_loader_pkg.sv
// Shared constants and state encoding for the imem loader.
// Used by imem_loader and the pcpu/imem wiring.
package imem_loader_pkg;

  localparam int IMEM_AW = 8;
  localparam int IMEM_DW = 16;
  localparam logic [7:0] HDR_DEF = 8'hA5;
  localparam logic [7:0] START_DEF = 8'h00;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COUNT,
    S_HI,
    S_LO,
    S_WRITE,
    S_CHK,
    S_DONE,
    S_ERR
  } state_e;

endpackage

// File: rtl/imem_loader.sv
// Framed byte-stream loader driving the imem write port; holds the pcpu in reset.
// Define IMEM_LOADER_CHECKSUM_EN to add the trailing XOR checksum byte and CHK/ERR path.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = IMEM_AW,
  parameter int DATA_W = IMEM_DW,
  parameter logic [7:0] HDR_BYTE = HDR_DEF,
  parameter logic [ADDR_W-1:0] START_ADDR = ADDR_W'(START_DEF)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0] wdata,
  output logic              done,
  output logic              error,
  output logic              cpu_hold
);

  state_e            r_state;
  state_e            w_next;
  logic              w_ready;
  logic              w_we;
  logic              w_acc;
  logic              w_hdr;
  logic [8:0]        r_count;
  logic [ADDR_W-1:0] r_waddr;
  logic [15:0]       r_wdata;
  logic              r_done;
  logic              r_hold;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        r_chk;
  logic              r_error;
`endif

  assign w_acc = rx_valid & w_ready;
  assign w_hdr = (r_state == S_IDLE) & w_acc & (rx_data == HDR_BYTE);

  always_comb begin
    w_next  = r_state;
    w_ready = 1'b0;
    w_we    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_ready = 1'b1;
        if (rx_valid && rx_data == HDR_BYTE) w_next = S_COUNT;
      end
      S_COUNT: begin
        w_ready = 1'b1;
        if (rx_valid) w_next = S_HI;
      end
      S_HI: begin
        w_ready = 1'b1;
        if (rx_valid) w_next = S_LO;
      end
      S_LO: begin
        w_ready = 1'b1;
        if (rx_valid) w_next = S_WRITE;
      end
      S_WRITE: begin
        w_we = 1'b1;
        // count still holds the pre-decrement value here
        if (r_count == 9'd1) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          w_next = S_CHK;
`else
          w_next = S_DONE;
`endif
        end else begin
          w_next = S_HI;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHK: begin
        w_ready = 1'b1;
        if (rx_valid) w_next = (rx_data == r_chk) ? S_DONE : S_ERR;
      end
`endif
      S_DONE:  w_next = S_IDLE;
      S_ERR:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_waddr <= START_ADDR;
      r_wdata <= '0;
      r_done  <= 1'b0;
      r_hold  <= 1'b1;
    end else begin
      r_state <= w_next;
      if (w_hdr) begin
        r_done  <= 1'b0;
        r_hold  <= 1'b1;
        r_waddr <= START_ADDR;
      end
      if (r_state == S_COUNT && w_acc)
        r_count <= (rx_data == 8'd0) ? 9'd256 : {1'b0, rx_data};
      if (r_state == S_HI && w_acc) r_wdata[15:8] <= rx_data;
      if (r_state == S_LO && w_acc) r_wdata[7:0] <= rx_data;
      if (r_state == S_WRITE) begin
        r_waddr <= r_waddr + 1'b1;
        r_count <= r_count - 9'd1;
      end
      if (w_next == S_DONE && r_state != S_DONE) begin
        r_done <= 1'b1;
        r_hold <= 1'b0;
      end
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_chk   <= '0;
      r_error <= 1'b0;
    end else begin
      if (w_hdr) begin
        r_chk   <= '0;
        r_error <= 1'b0;
      end
      if ((r_state == S_HI || r_state == S_LO) && w_acc)
        r_chk <= r_chk ^ rx_data;
      if (w_next == S_ERR && r_state != S_ERR) r_error <= 1'b1;
    end
  end
  assign error = r_error;
`else
  assign error = 1'b0;
`endif

  assign rx_ready = w_ready;
  assign we       = w_we;
  assign waddr    = r_waddr;
  assign wdata    = DATA_W'(r_wdata);
  assign done     = r_done;
  assign cpu_hold = r_hold;

endmodule
